// File: rtl/profile_sweep_ctrl_pkg.sv
// Shared types and constants for the profile sweep controller and its index counter.
package profile_sweep_ctrl_pkg;

    localparam int NUM_BINS = 8;
    localparam int SEL_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_READ
    } state_t;

endpackage

// File: rtl/profile_sweep_ctrl_index_counter.sv
// Nested bin/profiler counter for the readout sweep; bin is the fast index.
module sweep_index_counter
    import profile_sweep_ctrl_pkg::*;
#(
    parameter int NUM_PROF = 4,
    parameter int P_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [SEL_W-1:0] bin_idx,
    output logic [P_W-1:0]   prof_idx,
    output logic             last
);

    localparam logic [SEL_W-1:0] BIN_MAX  = SEL_W'(NUM_BINS - 1);
    localparam logic [P_W-1:0]   PROF_MAX = P_W'(NUM_PROF - 1);

    // NOTE: reset is sampled on the clock edge here, so it sits inside the clocked branch
    // rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            bin_idx  <= '0;
            prof_idx <= '0;
        end else if (advance) begin
            if (bin_idx == BIN_MAX) begin
                bin_idx  <= '0;
                prof_idx <= (prof_idx == PROF_MAX) ? '0 : prof_idx + 1'b1;
            end else begin
                bin_idx <= bin_idx + 1'b1;
            end
        end
    end

    assign last = (bin_idx == BIN_MAX) && (prof_idx == PROF_MAX);

endmodule

// File: rtl/profile_sweep_ctrl.sv
// Starts and stops a bank of 8-bin profilers, then streams every count out
// profiler-major, bin-minor over a valid/ready port.
module profile_sweep_ctrl
    import profile_sweep_ctrl_pkg::*;
#(
    parameter int NUM_PROF = 4,
    parameter int CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_start,
    input  logic                      cmd_stop,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_PROF-1:0]       prof_start,
    output logic [SEL_W-1:0]          prof_sel,
    input  logic [NUM_PROF*CNT_W-1:0] prof_count,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          out_data,
    output logic                      out_last
);

    localparam int P_W = (NUM_PROF > 1) ? $clog2(NUM_PROF) : 1;

    state_t           state;
    logic             xfer;
    logic             idx_last;
    logic [SEL_W-1:0] bin_idx;
    logic [P_W-1:0]   prof_idx;

    assign xfer = out_valid && out_ready;

    sweep_index_counter #(
        .NUM_PROF (NUM_PROF),
        .P_W      (P_W)
    ) u_index (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == ST_FLUSH),
        .advance  (xfer),
        .bin_idx  (bin_idx),
        .prof_idx (prof_idx),
        .last     (idx_last)
    );

    // NOTE: every register in this block uses <= so all of them see the
    // pre-edge values, whatever order the assignments are written in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            prof_start <= '0;
            out_valid  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        state      <= ST_RUN;
                        busy       <= 1'b1;
                        prof_start <= '1;
                    end
                end
                ST_RUN: begin
                    if (cmd_stop) begin
                        state      <= ST_FLUSH;
                        prof_start <= '0;
                    end
                end
                // One idle cycle lets the last in-flight increment land before readout.
                ST_FLUSH: begin
                    state     <= ST_READ;
                    out_valid <= 1'b1;
                end
                ST_READ: begin
                    if (xfer && idx_last) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    prof_start <= '0;
                    out_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign prof_sel = (state == ST_READ) ? bin_idx : '0;
    assign out_last = out_valid && idx_last;

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_PROF; i++) begin
            if (prof_idx == P_W'(i)) begin
                out_data = prof_count[i*CNT_W +: CNT_W];
            end
        end
    end

endmodule
